// File: rtl/mt_prefetch_buffer_if.sv
// mt_prefetch_buffer_if: bus-side and core-side signals of the prefetch buffer.
//   slave  : the prefetch buffer's view (bus requests and core_rv in, data/status/core controls out)
//   master : the surrounding logic's view (drives requests and core_rv, observes the rest)
// Signals:
//   seed_load, seed      reseed request and value
//   rd_req               pop request, one pulse per word
//   rd_data, rd_valid    head-of-FIFO word and non-empty flag
//   underflow            pulse: pop attempted while empty
//   level                current FIFO occupancy
//   core_load_value, core_value, core_gen_rv   controls to the mersenne_twister core
//   core_rv              random word from the core
interface mt_prefetch_buffer_if #(
  parameter int unsigned DEPTH = 4
) ();
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic             seed_load;
  logic [31:0]      seed;
  logic             rd_req;
  logic [31:0]      rd_data;
  logic             rd_valid;
  logic             underflow;
  logic [LVL_W-1:0] level;
  logic             core_load_value;
  logic [31:0]      core_value;
  logic             core_gen_rv;
  logic [31:0]      core_rv;

  modport slave (
    input  seed_load, seed, rd_req, core_rv,
    output rd_data, rd_valid, underflow, level,
           core_load_value, core_value, core_gen_rv
  );

  modport master (
    output seed_load, seed, rd_req, core_rv,
    input  rd_data, rd_valid, underflow, level,
           core_load_value, core_value, core_gen_rv
  );
endinterface

// File: rtl/mt_prefetch_buffer.sv
// mt_prefetch_buffer: keeps a FIFO of pre-generated 32-bit random numbers so
// bus reads pop with zero wait states. Refills in the background by pulsing the
// core's gen_rv, reserving a FIFO slot per outstanding request so it never
// overfills. Seed loads are forwarded to the core and flush every buffered or
// in-flight number produced under the old seed.
// Ports:
//   clk      system clock, rising edge
//   n_rst    asynchronous active-low reset (also resets the core)
//   bus_if   mt_prefetch_buffer_if.slave (bus requests, FIFO status, core controls)
// Parameters:
//   DEPTH    FIFO entries, power of two, 2..16
//   CORE_LAT cycles from a core_gen_rv pulse to a valid core_rv, 1..4
module mt_prefetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned CORE_LAT = 1
) (
  input logic                 clk,
  input logic                 n_rst,
  mt_prefetch_buffer_if.slave bus_if
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
  // Wide enough for level + inflight without overflow.
  localparam int unsigned CNT_W = LVL_W + 3;

  typedef enum logic {
    ST_FLUSH = 1'b0,
    ST_FILL  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [31:0]         mem_q [DEPTH];
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [CORE_LAT-1:0] pipe_q, pipe_d;
  logic                underflow_q, underflow_d;

  logic                rd_valid_c;
  logic                pop_c;
  logic                push_c;
  logic                room_c;
  logic                gen_c;
  logic                flush_c;
  logic [CNT_W-1:0]    inflight_c;

  // FIFO status and request accounting
  always_comb begin
    rd_valid_c = (level_q != '0);
    pop_c      = bus_if.rd_req && rd_valid_c;
    inflight_c = CNT_W'($countones(pipe_q));
    // Outstanding requests already own a slot, so count them as occupied.
    room_c     = (CNT_W'(level_q) + inflight_c - CNT_W'(pop_c)) < CNT_W'(DEPTH);
    // Results of pre-seed requests are never written.
    push_c     = (state_q == ST_FILL) && !bus_if.seed_load && pipe_q[CORE_LAT-1];
  end

  // FSM state register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_FLUSH;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a seed load always (re)enters FLUSH
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_FLUSH: state_d = bus_if.seed_load ? ST_FLUSH : ST_FILL;
      ST_FILL:  state_d = bus_if.seed_load ? ST_FLUSH : ST_FILL;
      default:  state_d = ST_FLUSH;
    endcase
  end

  // FSM outputs: refill pulses in FILL, flush in FLUSH or on a reseed
  always_comb begin
    gen_c   = 1'b0;
    flush_c = 1'b1;
    unique case (state_q)
      ST_FLUSH: begin
        gen_c   = 1'b0;
        flush_c = 1'b1;
      end
      ST_FILL: begin
        // No request alongside a seed load: its result would be discarded.
        gen_c   = !bus_if.seed_load && room_c;
        flush_c = bus_if.seed_load;
      end
      default: begin
        gen_c   = 1'b0;
        flush_c = 1'b1;
      end
    endcase
  end

  // Pointer, level and in-flight pipe next state
  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    level_d     = level_q;
    pipe_d      = CORE_LAT'({pipe_q, gen_c});
    underflow_d = bus_if.rd_req && !rd_valid_c;
    if (flush_c) begin
      // A pop in the reseed cycle was already served from rd_data; drop the rest.
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
      pipe_d   = '0;
    end else begin
      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push_c) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      case ({push_c, pop_c})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Control registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      level_q     <= '0;
      pipe_q      <= '0;
      underflow_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      level_q     <= level_d;
      pipe_q      <= pipe_d;
      underflow_q <= underflow_d;
    end
  end

  // FIFO storage; contents are only observed when level is non-zero
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= bus_if.core_rv;
    end
  end

  // Outputs: head word is shown combinationally, forced to 0 when empty
  assign bus_if.rd_data         = rd_valid_c ? mem_q[rd_ptr_q] : 32'h0;
  assign bus_if.rd_valid        = rd_valid_c;
  assign bus_if.underflow       = underflow_q;
  assign bus_if.level           = level_q;
  assign bus_if.core_load_value = bus_if.seed_load;
  assign bus_if.core_value      = bus_if.seed_load ? bus_if.seed : 32'h0;
  assign bus_if.core_gen_rv     = gen_c;

endmodule
